// File: rtl/awmf0165_pkg.sv
`default_nettype none
// ============================================================================
// Module : awmf0165_pkg -- state encoding and parameter defaults for the
//          AWMF-0165 SPI frame transmitter.          Rev : 1.0 initial release
// ============================================================================
package awmf0165_pkg;

   localparam int FIFO_DATA_W    = 256;

   localparam int FRAME_BITS_DEF = 256;
   localparam int SCLK_HALF_DEF  = 4;
   localparam int CS_SETUP_DEF   = 2;
   localparam int CS_HOLD_DEF    = 2;
   localparam int LDB_WIDTH_DEF  = 4;
   localparam int GAP_CYC_DEF    = 8;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] SETUP = 3'd3;
   localparam logic [2:0] SHIFT = 3'd4;
   localparam logic [2:0] HOLD  = 3'd5;
   localparam logic [2:0] LATCH = 3'd6;
   localparam logic [2:0] GAP   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/awmf0165_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module : awmf0165_sclk_gen -- SCLK divider, low phase first, cleared while
//          disabled.                                  Rev : 1.0 initial release
// ============================================================================
module awmf0165_sclk_gen #(
   parameter int SCLK_HALF = 4
) (
   input  logic read_clk,
   input  logic sys_rst,
   input  logic en,
   output logic sclk,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       tc;

   assign tc = (cnt_q == 8'(SCLK_HALF - 1));

   always_comb begin
      cnt_d  = 8'd0;
      sclk_d = 1'b0;
      if (en) begin
         if (tc) begin
            cnt_d  = 8'd0;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d  = cnt_q + 8'd1;
            sclk_d = sclk_q;
         end
      end
   end

   always_ff @(posedge read_clk) begin
      if (sys_rst) begin
         cnt_q  <= 8'd0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   // pulses flag the edge on which sclk is about to toggle
   assign sclk       = sclk_q;
   assign rise_pulse = en & tc & ~sclk_q;
   assign fall_pulse = en & tc &  sclk_q;

endmodule
`default_nettype wire

// File: rtl/awmf0165_spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : awmf0165_spi_frame_tx -- pops one FIFO word per frame, shifts it
//          MSB-first over SPI, then pulses LDB.       Rev : 1.0 initial release
// ============================================================================
module awmf0165_spi_frame_tx
   import awmf0165_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int SCLK_HALF  = SCLK_HALF_DEF,
   parameter int CS_SETUP   = CS_SETUP_DEF,
   parameter int CS_HOLD    = CS_HOLD_DEF,
   parameter int LDB_WIDTH  = LDB_WIDTH_DEF,
   parameter int GAP_CYC    = GAP_CYC_DEF
) (
   input  logic                   read_clk,
   input  logic                   sys_rst,
   input  logic                   tx_enable,
   input  logic                   adsdata_fifo_empty,
   input  logic [FIFO_DATA_W-1:0] read_data_i,
   output logic                   read_data_en,
   output logic                   spi_csb,
   output logic                   spi_sclk,
   output logic                   spi_sdi,
   output logic                   spi_ldb,
   output logic                   tx_busy,
   output logic                   frame_done,
   output logic [15:0]            frame_cnt
);

   logic [2:0]            state_q, state_d;
   logic [7:0]            cyc_q, cyc_d;
   logic [8:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_reg_q, shift_reg_d;
   logic                  rd_en_q, rd_en_d;
   logic                  csb_q, csb_d;
   logic                  sdi_q, sdi_d;
   logic                  ldb_q, ldb_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;

   logic                  shift_en;
   logic                  fall_pulse;
   logic                  rise_unused;
   logic                  unused_ok;

   assign shift_en = (state_q == SHIFT);

   awmf0165_sclk_gen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_sclk_gen (
      .read_clk   (read_clk),
      .sys_rst    (sys_rst),
      .en         (shift_en),
      .sclk       (spi_sclk),
      .rise_pulse (rise_unused),
      .fall_pulse (fall_pulse)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (tx_enable && !adsdata_fifo_empty) state_d = WAIT;
         WAIT:  state_d = LOAD;
         LOAD:  state_d = SETUP;
         SETUP: if (cyc_q == 8'(CS_SETUP - 1)) state_d = SHIFT;
         SHIFT: if (fall_pulse && (bit_cnt_q == 9'd1)) state_d = HOLD;
         HOLD:  if (cyc_q == 8'(CS_HOLD - 1)) state_d = LATCH;
         LATCH: if (cyc_q == 8'(LDB_WIDTH - 1)) state_d = (GAP_CYC == 0) ? IDLE : GAP;
         GAP:   if (cyc_q == 8'(GAP_CYC - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Every registered output is derived from the next state so that it
   // changes on the same edge as the state itself.
   always_comb begin
      cyc_d       = (state_d != state_q) ? 8'd0 : cyc_q + 8'd1;
      shift_reg_d = shift_reg_q;
      bit_cnt_d   = bit_cnt_q;
      sdi_d       = sdi_q;

      if (state_q == LOAD) begin
         shift_reg_d = read_data_i[FIFO_DATA_W-1 -: FRAME_BITS];
         bit_cnt_d   = 9'(FRAME_BITS);
         sdi_d       = read_data_i[FIFO_DATA_W-1];
      end else if (shift_en && fall_pulse) begin
         bit_cnt_d = bit_cnt_q - 9'd1;
         if (bit_cnt_q != 9'd1) begin
            shift_reg_d = {shift_reg_q[FRAME_BITS-2:0], 1'b0};
            sdi_d       = shift_reg_q[FRAME_BITS-2];
         end
      end
      if (state_d == LATCH || state_d == GAP || state_d == IDLE) sdi_d = 1'b0;

      rd_en_d     = (state_q == IDLE) && (state_d == WAIT);
      csb_d       = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
      ldb_d       = (state_d != LATCH);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == LATCH) && (cyc_d == 8'(LDB_WIDTH - 1));
      frame_cnt_d = frame_cnt_q;
      if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge read_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         cyc_q       <= 8'd0;
         bit_cnt_q   <= 9'd0;
         shift_reg_q <= '0;
         rd_en_q     <= 1'b0;
         csb_q       <= 1'b1;
         sdi_q       <= 1'b0;
         ldb_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_reg_q <= shift_reg_d;
         rd_en_q     <= rd_en_d;
         csb_q       <= csb_d;
         sdi_q       <= sdi_d;
         ldb_q       <= ldb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign read_data_en = rd_en_q;
   assign spi_csb      = csb_q;
   assign spi_sdi      = sdi_q;
   assign spi_ldb      = ldb_q;
   assign tx_busy      = busy_q;
   assign frame_done   = done_q;
   assign frame_cnt    = frame_cnt_q;

   // Bits below the frame window, the shifted-out MSB and the rise strobe
   // have no consumer here.
   assign unused_ok = ^{read_data_i, shift_reg_q[FRAME_BITS-1], rise_unused};

endmodule
`default_nettype wire
